// File: rtl/timer_arbiter_pkg.sv
// timer_arbiter_pkg: shared FSM encoding and default sizing
// for the round-robin timer arbiter.
package timer_arbiter_pkg;

    localparam int N_DEF = 4;
    localparam int W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/timer_arbiter_if.sv
// timer_arbiter_if: requester bus plus timer load/enable/count bus.
// master = arbiter side, slave = requesters + timer side.
interface timer_arbiter_if #(
    parameter int N = 4,
    parameter int W = 5
) ();
    logic [N-1:0]   req;
    logic [N*W-1:0] req_value;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           busy;
    logic [W-1:0]   tmr_value;
    logic           tmr_valid;
    logic           tmr_enable;
    logic [W-1:0]   tmr_count;

    modport master (
        input  req, req_value, tmr_count,
        output gnt, done, busy,
        output tmr_value, tmr_valid, tmr_enable
    );

    modport slave (
        output req, req_value, tmr_count,
        input  gnt, done, busy,
        input  tmr_value, tmr_valid, tmr_enable
    );
endinterface

// File: rtl/timer_arbiter_rr.sv
// rr_arbiter_n: combinational round-robin pick.
// Ports: req (N), ptr (start index) -> found, index of first set bit.
module rr_arbiter_n #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] index
);
    int            j;
    logic [IW-1:0] jj;

    always_comb begin
        found = 1'b0;
        index = '0;
        j     = 0;
        jj    = '0;
        // scan ptr, ptr+1, ... wrapping explicitly at N
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            jj = IW'(j);
            if (!found && req[jj]) begin
                found = 1'b1;
                index = jj;
            end
        end
    end
endmodule

// File: rtl/timer_arbiter.sv
// timer_arbiter: shares one down-counting timer between N requesters.
// Ports: clk, reset (sync, active-low), bus (timer_arbiter_if.master).
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    timer_arbiter_if.master bus
);
    localparam int IW = $clog2(N);

    state_t        state, state_n;
    logic [IW-1:0] owner;
    logic [IW-1:0] ptr;
    logic [IW-1:0] pick;
    logic [W-1:0]  value;
    logic          found;
    logic          own_req;
    logic          abort;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        return (i == IW'(N - 1)) ? '0 : i + 1'b1;
    endfunction

    rr_arbiter_n #(.N(N)) u_rr (
        .req   (bus.req),
        .ptr   (ptr),
        .found (found),
        .index (pick)
    );

    assign own_req = bus.req[owner];
    assign abort   = (state == LOAD || state == RUN) && !own_req;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
            value <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && found) begin
                owner <= pick;
                value <= bus.req_value[int'(pick)*W +: W];
            end
            // advance past the owner on completion or abort
            if (state == DONE || abort)
                ptr <= wrap_inc(owner);
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (found) state_n = LOAD;
            LOAD: state_n = own_req ? RUN : IDLE;
            RUN: begin
                if (!own_req)
                    state_n = IDLE;
                else if (bus.tmr_count == '0)
                    state_n = DONE;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        bus.gnt        = '0;
        bus.done       = '0;
        bus.busy       = (state != IDLE);
        bus.tmr_valid  = 1'b0;
        bus.tmr_value  = '0;
        bus.tmr_enable = (state == RUN) && (bus.tmr_count != '0);
        unique case (state)
            LOAD: begin
                bus.gnt[owner] = 1'b1;
                bus.tmr_valid  = 1'b1;
                bus.tmr_value  = value;
            end
            RUN:  bus.gnt[owner] = 1'b1;
            DONE: begin
                bus.gnt[owner]  = 1'b1;
                bus.done[owner] = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: directed + random checks of timer_arbiter
// against a transaction-level model with a behavioural timer.
module tb_timer_arbiter;
    localparam int N = 4;
    localparam int W = 5;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    timer_arbiter_if #(.N(N), .W(W)) bus ();

    timer_arbiter #(.N(N), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [N-1:0] mask = '0;
    logic [W-1:0] vals [N];
    logic [W-1:0] cnt = '0;
    int errors = 0;
    int checks = 0;
    int m_ptr = 0;

    assign bus.req       = mask;
    assign bus.tmr_count = cnt;
    for (genvar g = 0; g < N; g++) begin : g_val
        assign bus.req_value[g*W +: W] = vals[g];
    end

    // behavioural timer: load wins, else decrement to zero
    always @(posedge clk) begin
        if (bus.tmr_valid)
            cnt <= bus.tmr_value;
        else if (bus.tmr_enable && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_gnt"}, 32'(bus.gnt), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_en"}, 32'(bus.tmr_enable), 0);
        chk({tag, "_valid"}, 32'(bus.tmr_valid), 0);
    endtask

    function automatic int pick(input logic [N-1:0] m, input int p);
        logic [N-1:0] t;
        for (int k = 0; k < N; k++) begin
            t = m >> ((p + k) % N);
            if (t[0]) return (p + k) % N;
        end
        return -1;
    endfunction

    // one arbitration round starting in an IDLE cycle
    task automatic grant(input int abort_at, input bit keep,
                         input bit poke);
        int o;
        logic [W-1:0] v;
        o = pick(mask, m_ptr);
        if (o < 0) begin
            tick;
            chk("idle_stay", 32'(bus.busy), 0);
            return;
        end
        v = vals[o];
        tick;
        chk("load_gnt", 32'(bus.gnt), 1 << o);
        chk("load_valid", 32'(bus.tmr_valid), 1);
        chk("load_value", 32'(bus.tmr_value), 32'(v));
        chk("load_busy", 32'(bus.busy), 1);
        for (int k = 0; k <= int'(v); k++) begin
            tick;
            chk("run_gnt", 32'(bus.gnt), 1 << o);
            chk("run_en", 32'(bus.tmr_enable), (k < int'(v)) ? 1 : 0);
            chk("run_done", 32'(bus.done), 0);
            if (poke && k == 0) vals[o] = vals[o] ^ 5'h03;
            if (k == abort_at) begin
                mask[o] = 1'b0;
                tick;
                chk_idle("abort");
                m_ptr = (o + 1) % N;
                return;
            end
        end
        tick;
        chk("done_pulse", 32'(bus.done), 1 << o);
        chk("done_gnt", 32'(bus.gnt), 1 << o);
        chk("done_en", 32'(bus.tmr_enable), 0);
        if (!keep) mask[o] = 1'b0;
        m_ptr = (o + 1) % N;
        tick;
        chk_idle("post");
    endtask

    initial begin
        for (int i = 0; i < N; i++) vals[i] = '0;
        reset = 1'b0;
        tick;
        tick;
        chk_idle("reset");
        chk("reset_value", 32'(bus.tmr_value), 0);
        reset = 1'b1;

        vals[0] = 5'd3;
        mask = 4'b0001;
        grant(-1, 0, 0);

        vals[1] = 5'd2;
        vals[3] = 5'd5;
        mask = 4'b1010;
        grant(-1, 0, 0);
        grant(-1, 0, 0);
        mask = 4'b0011;
        grant(-1, 0, 0);
        grant(-1, 0, 0);

        for (int i = 0; i < N; i++) vals[i] = 5'd1;
        mask = 4'b1111;
        repeat (5) grant(-1, 1, 0);
        mask = '0;
        grant(-1, 0, 0);

        vals[0] = 5'd0;
        mask = 4'b0001;
        grant(-1, 0, 0);

        vals[2] = 5'd10;
        mask = 4'b0100;
        grant(1, 0, 0);
        mask = 4'b1101;
        repeat (3) grant(-1, 0, 0);

        vals[1] = 5'd6;
        mask = 4'b0010;
        tick;
        tick;
        tick;
        vals[1] = 5'd9;
        reset = 1'b0;
        tick;
        chk_idle("rst_mid");
        chk("rst_mid_value", 32'(bus.tmr_value), 0);
        reset = 1'b1;
        m_ptr = 0;
        mask = 4'b1111;
        for (int i = 0; i < N; i++) vals[i] = 5'd2;
        grant(-1, 0, 1);
        grant(-1, 0, 1);
        mask = '0;

        for (int it = 0; it < 40; it++) begin
            mask = mask | N'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) vals[i] = W'($urandom_range(0, 6));
            grant(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1,
                  0, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
